imem_loader: RTL and testbench

- Boot-time program loader that sits directly upstream of the mips core.
- Accepts a byte stream over a valid/ready interface and assembles it into 32-bit instruction words.
- Writes those words into instruction memory, verifies an XOR checksum, then asserts cpu_run to release the core.
- Replaces hand-initialised instruction memory so benches and the board load programs the same way.

---
 rtl/imem_loader.sv | 78 +++++++
 tb/tb_imem_loader.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: assembles a length-prefixed, XOR-checksummed byte stream into instruction memory, then releases the core.
module imem_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_run,
  output logic                  done,
  output logic                  error
);
  typedef enum logic [2:0] {S_CNT_HI, S_CNT_LO, S_DATA, S_CSUM, S_RUN, S_ERR} state_t;
  localparam logic [16:0] CAP = 17'(1) << ADDR_WIDTH;
  state_t state, state_n;
  logic [15:0] count, n_full;
  logic [1:0] byte_idx;
  logic [ADDR_WIDTH:0] word_idx;
  logic [7:0] csum;
  logic [23:0] shreg;
  logic acc, last_byte, last_word, word_done;
  always_comb begin
    rx_ready = state == S_CNT_HI || state == S_CNT_LO || state == S_DATA || state == S_CSUM;
    acc = rx_valid && rx_ready;
    n_full = {count[15:8], rx_data};
    last_byte = byte_idx == 2'd3;
    last_word = 16'(word_idx) + 16'd1 == count;
    word_done = acc && state == S_DATA && last_byte;
    state_n = state;
    if (acc)
      case (state)
        S_CNT_HI: state_n = S_CNT_LO;
        S_CNT_LO: state_n = 17'(n_full) > CAP ? S_ERR : n_full == 16'd0 ? S_CSUM : S_DATA;
        S_DATA:   state_n = last_byte && last_word ? S_CSUM : S_DATA;
        S_CSUM:   state_n = rx_data == csum ? S_RUN : S_ERR;
        default:  state_n = state;
      endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_CNT_HI;
      count <= '0;
      byte_idx <= '0;
      word_idx <= '0;
      csum <= '0;
      shreg <= '0;
      imem_we <= 1'b0;
      imem_addr <= '0;
      imem_wdata <= '0;
      cpu_run <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
    end else begin
      state <= state_n;
      imem_we <= word_done;
      cpu_run <= state_n == S_RUN;
      done <= state_n == S_RUN;
      error <= state_n == S_ERR;
      if (acc && state == S_CNT_HI) count[15:8] <= rx_data;
      if (acc && state == S_CNT_LO) count[7:0] <= rx_data;
      if (acc && state == S_DATA) begin
        shreg <= {shreg[15:0], rx_data};
        csum <= csum ^ rx_data;
        byte_idx <= byte_idx + 2'd1;
      end
      // word index is one bit wider than the address so a full-capacity load never wraps
      if (word_done) begin
        imem_addr <= word_idx[ADDR_WIDTH-1:0];
        imem_wdata <= {shreg, rx_data};
        word_idx <= word_idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: random and directed frames checked against a byte-level frame model.
module tb_imem_loader;
  logic clock = 0, reset = 1, rx_valid = 0, rx_ready, imem_we, cpu_run, done, error;
  logic [7:0] rx_data = 0, imem_addr;
  logic [31:0] imem_wdata;
  int n_chk = 0, n_fail = 0;
  int wr_addr[$];
  logic [31:0] wr_data[$];
  logic [31:0] exp_words[$];

  imem_loader #(.ADDR_WIDTH(8)) dut (
    .clock(clock), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_run(cpu_run), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  always @(negedge clock)
    if (imem_we) begin
      wr_addr.push_back(int'(imem_addr));
      wr_data.push_back(imem_wdata);
    end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t = 0;
    rx_valid = 1;
    rx_data = b;
    while (!rx_ready && t < 20) begin
      tick();
      t++;
    end
    if (!rx_ready) begin
      check("ready_timeout", 32'(rx_ready), 1);
      rx_valid = 0;
      return;
    end
    tick();
    rx_valid = 0;
    repeat (gap) tick();
  endtask

  task automatic do_reset();
    rx_valid = 0;
    reset = 1;
    tick();
    reset = 0;
    wr_addr.delete();
    wr_data.delete();
    check("rst_ready", 32'(rx_ready), 1);
    check("rst_we", 32'(imem_we), 0);
    check("rst_addr", 32'(imem_addr), 0);
    check("rst_wdata", imem_wdata, 0);
    check("rst_run", 32'(cpu_run), 0);
    check("rst_done", 32'(done), 0);
    check("rst_error", 32'(error), 0);
  endtask

  function automatic void rand_words(input int n);
    exp_words.delete();
    for (int i = 0; i < n; i++) exp_words.push_back($urandom());
  endfunction

  // model: a frame is good iff N fits and the checksum byte equals the XOR of all data bytes
  task automatic run_frame(input int n, input int gap_max, input int csum_force);
    logic [7:0] cs = 0, cb;
    bit good;
    send_byte(8'(n >> 8), int'($urandom_range(gap_max, 0)));
    send_byte(8'(n), int'($urandom_range(gap_max, 0)));
    if (n > 256) begin
      check("ovf_error", 32'(error), 1);
      check("ovf_ready", 32'(rx_ready), 0);
      check("ovf_run", 32'(cpu_run), 0);
      check("ovf_we_cnt", wr_addr.size(), 0);
      return;
    end
    for (int i = 0; i < n; i++)
      for (int k = 3; k >= 0; k--) begin
        cs ^= exp_words[i][8*k +: 8];
        send_byte(exp_words[i][8*k +: 8], int'($urandom_range(gap_max, 0)));
      end
    cb = csum_force < 0 ? cs : 8'(csum_force);
    good = cb == cs;
    check("pre_done", 32'(done), 0);
    send_byte(cb, 0);
    check("done", 32'(done), 32'(good));
    check("cpu_run", 32'(cpu_run), 32'(good));
    check("error", 32'(error), 32'(!good));
    check("ready_after", 32'(rx_ready), 0);
    check("we_cnt", wr_addr.size(), n);
    for (int i = 0; i < n && i < wr_addr.size(); i++) begin
      check("wr_addr", wr_addr[i], i);
      check("wr_data", wr_data[i], exp_words[i]);
    end
    rx_valid = 1;
    rx_data = 8'($urandom());
    repeat (3) tick();
    rx_valid = 0;
    check("hold_we_cnt", wr_addr.size(), n);
    check("hold_done", 32'(done), 32'(good));
    check("hold_error", 32'(error), 32'(!good));
  endtask

  initial begin
    do_reset();
    exp_words = '{32'h20080005, 32'hAC090004};
    run_frame(2, 0, 8'h8C);
    do_reset();
    run_frame(2, 0, 8'h26);
    do_reset();
    rand_words(0);
    run_frame(0, 0, 0);
    do_reset();
    run_frame(257, 0, -1);
    do_reset();
    exp_words = '{32'h12345678};
    run_frame(1, 1, 8'h08);
    // reset after header plus five data bytes keeps the first word only
    do_reset();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    foreach (exp_words[i]) ;
    for (int i = 0; i < 5; i++) send_byte(8'(8'h40 + i), 0);
    check("mid_we_cnt", wr_addr.size(), 1);
    do_reset();
    exp_words = '{32'hCAFEF00D};
    run_frame(1, 0, -1);
    // reset coinciding with the 4th byte suppresses the write
    do_reset();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    for (int i = 0; i < 3; i++) send_byte(8'(i), 0);
    rx_valid = 1;
    rx_data = 8'h99;
    reset = 1;
    tick();
    reset = 0;
    rx_valid = 0;
    tick();
    check("rst4_we_cnt", wr_addr.size(), 0);
    check("rst4_ready", 32'(rx_ready), 1);
    do_reset();
    rand_words(256);
    run_frame(256, 0, -1);
    do_reset();
    run_frame(16'hFFFF, 0, -1);
    for (int r = 0; r < 20; r++) begin
      int n = int'($urandom_range(6, 0));
      do_reset();
      rand_words(n);
      run_frame(n, int'($urandom_range(2, 0)), ($urandom_range(3, 0) == 0) ? int'($urandom_range(255, 0)) : -1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
